// File: rtl/ssd_load_fsm_pkg.sv
// Shared definitions for the SSD load/rotate control stage: display-state
// codes, seven-segment patterns and the load-sequence character ROM.
package ssd_load_fsm_pkg;

    // Display-state codes driven onto the SSD controller's state input.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_ROTATE = 2'd2;

    // Seven-segment patterns, bit order {a,b,c,d,e,f,g,dp}, active-low.
    localparam logic [7:0] SS_0 = 8'b0000_0011;
    localparam logic [7:0] SS_N = 8'b1101_0101;
    localparam logic [7:0] SS_T = 8'b1110_0001;
    localparam logic [7:0] SS_H = 8'b1001_0001;
    localparam logic [7:0] SS_U = 8'b1000_0011;
    localparam logic [7:0] SS_E = 8'b0110_0001;
    localparam logic [7:0] SS_C = 8'b0110_0011;
    localparam logic [7:0] SS_S = 8'b0100_1001;

    // Last character index of the load sequence.
    localparam logic [2:0] LAST_POS = 3'd7;

    // Character ROM for the load sequence N,T,H,U,E,E,C,S.
    function automatic logic [7:0] ss_char(input logic [2:0] pos);
        logic [7:0] pat;
        pat = SS_0;
        case (pos)
            3'd0: pat = SS_N;
            3'd1: pat = SS_T;
            3'd2: pat = SS_H;
            3'd3: pat = SS_U;
            3'd4: pat = SS_E;
            3'd5: pat = SS_E;
            3'd6: pat = SS_C;
            3'd7: pat = SS_S;
            default: pat = SS_0;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/ssd_load_fsm_btn_debounce.sv
// Button conditioning: 2-flop synchroniser, stable-level debounce counter and
// rising-edge one-pulse. The pulse is exactly one clk wide per accepted press.
module btn_debounce_onepulse #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic [1:0]  r_sync;
    logic        r_stable;
    logic        r_stable_d;
    logic [15:0] r_cnt;
    logic        w_sync;

    assign w_sync = r_sync[1];

    // Bring the raw asynchronous button into the clk domain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive differing samples;
    // any sample matching the accepted level restarts the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (w_sync == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == DEB_CYCLES - 16'd1) begin
            r_stable <= w_sync;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Delayed copy of the accepted level for rising-edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable_d <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
        end
    end

    assign o_pulse = r_stable & ~r_stable_d;

endmodule

// File: rtl/ssd_load_fsm.sv
// Upstream control for the SSD controller: debounced LOAD/ROT buttons drive an
// IDLE/LOAD/ROTATE FSM that paces an 8-character load on an external tick.
module ssd_load_fsm
    import ssd_load_fsm_pkg::*;
#(
    parameter logic [15:0] DEB_CYCLES     = 16'd50000,
    parameter logic [3:0]  TICKS_PER_CHAR = 4'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_load,
    input  logic       btn_rot,
    output logic [1:0] state,
    output logic [7:0] code_in,
    output logic [2:0] load_position,
    output logic       load_done
);

    logic       w_load_p;
    logic       w_rot_p;

    logic [1:0] r_state;
    logic [7:0] r_code;
    logic [2:0] r_pos;
    logic       r_done;
    logic [3:0] r_tick_cnt;

    logic [1:0] w_state_nxt;
    logic [7:0] w_code_nxt;
    logic [2:0] w_pos_nxt;
    logic       w_done_nxt;
    logic [3:0] w_cnt_nxt;

    btn_debounce_onepulse #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn_load),
        .o_pulse (w_load_p)
    );

    btn_debounce_onepulse #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rot (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn_rot),
        .o_pulse (w_rot_p)
    );

    // Next-state, pacing and position logic. load_p is tested first in every
    // state so it wins over a coincident rot_p or tick.
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_done_nxt  = r_done;
        w_cnt_nxt   = r_tick_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_load_p) begin
                    w_state_nxt = ST_LOAD;
                    w_pos_nxt   = '0;
                    w_done_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end
            ST_LOAD: begin
                if (w_load_p) begin
                    w_pos_nxt  = '0;
                    w_done_nxt = 1'b0;
                    w_cnt_nxt  = '0;
                end else if (r_done) begin
                    w_pos_nxt = LAST_POS;
                    if (w_rot_p) begin
                        w_state_nxt = ST_ROTATE;
                        w_done_nxt  = 1'b0;
                    end
                end else if (tick) begin
                    if (r_tick_cnt == TICKS_PER_CHAR - 4'd1) begin
                        w_cnt_nxt = '0;
                        if (r_pos != LAST_POS) begin
                            w_pos_nxt = r_pos + 3'd1;
                        end
                        w_done_nxt = (w_pos_nxt == LAST_POS);
                    end else begin
                        w_cnt_nxt = r_tick_cnt + 4'd1;
                    end
                end
            end
            ST_ROTATE: begin
                if (w_load_p) begin
                    w_state_nxt = ST_LOAD;
                    w_pos_nxt   = '0;
                    w_done_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end else if (w_rot_p) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // code_in tracks ROM[load_position] while in LOAD and holds otherwise, so
    // ROTATE keeps showing the last loaded character.
    always_comb begin
        w_code_nxt = r_code;
        if (w_state_nxt == ST_LOAD) begin
            w_code_nxt = ss_char(w_pos_nxt);
        end
    end

    // Register FSM state and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_code     <= SS_0;
            r_pos      <= '0;
            r_done     <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_code     <= w_code_nxt;
            r_pos      <= w_pos_nxt;
            r_done     <= w_done_nxt;
            r_tick_cnt <= w_cnt_nxt;
        end
    end

    assign state         = r_state;
    assign code_in       = r_code;
    assign load_position = r_pos;
    assign load_done     = r_done;

endmodule

// File: tb/tb_ssd_load_fsm.sv
// Directed bench for ssd_load_fsm with a snapshot scoreboard.
module tb_ssd_load_fsm;
    import ssd_load_fsm_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0, btn_load = 1'b0, btn_rot = 1'b0;
    logic tick3 = 1'b0, btn_load3 = 1'b0, btn_rot3 = 1'b0;

    logic [1:0] state, state3;
    logic [7:0] code_in, code_in3;
    logic [2:0] load_position, load_position3;
    logic       load_done, load_done3;

    ssd_load_fsm #(.DEB_CYCLES(16'd4), .TICKS_PER_CHAR(4'd1)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn_load(btn_load), .btn_rot(btn_rot),
        .state(state), .code_in(code_in), .load_position(load_position), .load_done(load_done)
    );

    ssd_load_fsm #(.DEB_CYCLES(16'd4), .TICKS_PER_CHAR(4'd3)) dut3 (
        .clk(clk), .rst_n(rst_n), .tick(tick3), .btn_load(btn_load3), .btn_rot(btn_rot3),
        .state(state3), .code_in(code_in3), .load_position(load_position3), .load_done(load_done3)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic [7:0] code;
        logic [2:0] pos;
        logic       done;
    } snap_t;

    snap_t      exp_q[$];
    string      tag_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] rom [0:7];
    int         trans;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_snap(input string tag, input logic [1:0] st, input logic [7:0] code,
                               input logic [2:0] pos, input logic done);
        snap_t s;
        s.st = st; s.code = code; s.pos = pos; s.done = done;
        exp_q.push_back(s);
        tag_q.push_back(tag);
    endtask

    task automatic check_snap(input bit sel3);
        snap_t obs, expv;
        string tag;
        expv = exp_q.pop_front();
        tag  = tag_q.pop_front();
        if (sel3) obs = {state3, code_in3, load_position3, load_done3};
        else      obs = {state, code_in, load_position, load_done};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Hold the selected buttons for 10 cycles, release for 10; count state changes.
    task automatic press(input logic ld, input logic rt, output int n_trans);
        logic [1:0] prev;
        n_trans = 0;
        prev = state;
        btn_load = ld;
        btn_rot  = rt;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                btn_load = 1'b0;
                btn_rot  = 1'b0;
            end
            step(1);
            if (state !== prev) n_trans++;
            prev = state;
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic pulse_tick3();
        tick3 = 1'b1;
        step(1);
        tick3 = 1'b0;
    endtask

    initial begin
        rom = '{SS_N, SS_T, SS_H, SS_U, SS_E, SS_E, SS_C, SS_S};

        // 1. Reset held with inputs toggling.
        for (int i = 0; i < 6; i++) begin
            btn_load = i[0];
            btn_rot  = ~i[0];
            tick     = i[0];
            expect_snap("reset", ST_IDLE, SS_0, 3'd0, 1'b0);
            step(1);
            check_snap(1'b0);
        end
        btn_load = 1'b0; btn_rot = 1'b0; tick = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(2);
        expect_snap("post_reset", ST_IDLE, SS_0, 3'd0, 1'b0);
        check_snap(1'b0);

        // 2. Full load.
        expect_snap("enter_load", ST_LOAD, SS_N, 3'd0, 1'b0);
        press(1'b1, 1'b0, trans);
        check_int("load_transitions", trans, 1);
        check_snap(1'b0);
        for (int k = 1; k <= 7; k++) begin
            expect_snap("load_step", ST_LOAD, rom[k], 3'(k), (k == 7));
            pulse_tick();
            check_snap(1'b0);
            step(1);
        end
        for (int k = 0; k < 3; k++) begin
            expect_snap("hold_pos7", ST_LOAD, SS_S, 3'd7, 1'b1);
            pulse_tick();
            check_snap(1'b0);
        end

        // 3. Bounce rejection on ROT (a pulse here would leave LOAD).
        begin
            logic [1:0] prev;
            trans = 0;
            prev = state;
            expect_snap("bounce", ST_LOAD, SS_S, 3'd7, 1'b1);
            for (int i = 0; i < 30; i++) begin
                btn_rot = (i < 20) ? (((i / 2) % 2) == 0) : 1'b0;
                step(1);
                if (state !== prev) trans++;
                prev = state;
            end
            check_int("bounce_transitions", trans, 0);
            check_snap(1'b0);
        end

        // 4. Handover to ROTATE, then exit to IDLE.
        expect_snap("to_rotate", ST_ROTATE, SS_S, 3'd7, 1'b0);
        press(1'b0, 1'b1, trans);
        check_int("rot_transitions", trans, 1);
        check_snap(1'b0);
        expect_snap("rotate_tick_ignored", ST_ROTATE, SS_S, 3'd7, 1'b0);
        pulse_tick();
        check_snap(1'b0);
        expect_snap("to_idle", ST_IDLE, SS_S, 3'd7, 1'b0);
        press(1'b0, 1'b1, trans);
        check_snap(1'b0);

        // 5a. Restart at position 4 with a coincident tick.
        expect_snap("reload", ST_LOAD, SS_N, 3'd0, 1'b0);
        press(1'b1, 1'b0, trans);
        check_snap(1'b0);
        for (int k = 0; k < 4; k++) pulse_tick();
        expect_snap("at_pos4", ST_LOAD, SS_E, 3'd4, 1'b0);
        check_snap(1'b0);
        // load_p is high during the 7th cycle after the raw edge.
        expect_snap("restart_collision", ST_LOAD, SS_N, 3'd0, 1'b0);
        btn_load = 1'b1;
        step(6);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        check_snap(1'b0);
        step(3);
        btn_load = 1'b0;
        step(10);
        expect_snap("restart_settled", ST_LOAD, SS_N, 3'd0, 1'b0);
        check_snap(1'b0);

        // 5b. load_p and rot_p together in ROTATE.
        for (int k = 0; k < 7; k++) pulse_tick();
        press(1'b0, 1'b1, trans);
        expect_snap("rotate_again", ST_ROTATE, SS_S, 3'd7, 1'b0);
        check_snap(1'b0);
        expect_snap("both_buttons", ST_LOAD, SS_N, 3'd0, 1'b0);
        press(1'b1, 1'b1, trans);
        check_snap(1'b0);

        // 6. Pacing with TICKS_PER_CHAR=3.
        expect_snap("p3_enter", ST_LOAD, SS_N, 3'd0, 1'b0);
        btn_load3 = 1'b1;
        step(10);
        btn_load3 = 1'b0;
        step(10);
        check_snap(1'b1);
        for (int k = 1; k <= 21; k++) begin
            expect_snap("p3_step", ST_LOAD, rom[k / 3], 3'(k / 3), ((k / 3) == 7));
            pulse_tick3();
            check_snap(1'b1);
        end

        // Asynchronous reset mid-load.
        press(1'b1, 1'b0, trans);
        for (int k = 0; k < 3; k++) pulse_tick();
        expect_snap("mid_load_pos3", ST_LOAD, SS_U, 3'd3, 1'b0);
        check_snap(1'b0);
        expect_snap("async_reset", ST_IDLE, SS_0, 3'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_snap(1'b0);
        expect_snap("async_reset_dut3", ST_IDLE, SS_0, 3'd0, 1'b0);
        check_snap(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
